store_rmw: RTL
==============

Name: store_rmw

Overview:
- Store-side counterpart of the load-extension path.
- Converts sw/sb/sh store requests from the MEM stage into full-word writes to a word-only data memory that has no byte enables.
- Sub-word stores run a read-modify-write sequence. The FSM stalls the pipeline via busy until the write completes.
- Also flags misaligned stores, and performs no memory access when it does.

Parameters:
- RD_LAT, 1, cycles from the mem_re cycle to the cycle where mem_rdata is valid; legal range 1..3.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  store request present (sampled only in IDLE)
- req_op  input  2  00=sw, 01=sb, 10=sh, 11=reserved
- req_addr  input  32  byte address
- req_data  input  32  store data (rt value); sb uses [7:0], sh uses [15:0]
- busy  output  1  high whenever the FSM is not in IDLE; the pipeline stalls on it
- mem_addr  output  32  word address to memory, always {addr_q[31:2],2'b00}
- mem_re  output  1  memory read strobe
- mem_rdata  input  32  memory read data
- mem_we  output  1  memory write strobe (full word)
- mem_wdata  output  32  merged write data
- mem_be  output  4  byte lanes actually modified (informational, for trace/checker)
- done  output  1  one-cycle pulse, coincident with the mem_we cycle
- misalign  output  1  one-cycle pulse on a rejected misaligned request

Behaviour:
- Reset: state=IDLE; busy, mem_re, mem_we, done and misalign are 0; mem_addr, mem_wdata and mem_be are 0; the capture registers are cleared.
- All outputs are registered or decoded from registered state. There is no combinational path from req_* to any output.
- IDLE, when req_valid=1:
  - The request is misaligned if it is sw with addr[1:0]!=0, or sh with addr[0]=1.
  - Misaligned: pulse misalign the next cycle, stay in IDLE, no memory access.
  - op=11: ignore the request, no pulse.
  - Otherwise: latch op, addr and data into op_q, addr_q and data_q.
  - sw goes to WRITE; sb/sh go to READ.
- READ, 1 cycle: mem_re=1. Then go to WAIT, with cnt=0.
- WAIT: cnt increments each cycle. When cnt==RD_LAT-1, capture mem_rdata into the merge register and go to MERGE.
- MERGE, 1 cycle, builds the merged word:
  - sb: replace byte lane addr_q[1:0] with data_q[7:0].
  - sh: replace halfword lane addr_q[1] with data_q[15:0].
  - All other bits are kept from the read word.
- WRITE, 1 cycle: mem_we=1, done=1, mem_wdata and mem_be valid. Then go to IDLE.
  - sw: mem_wdata=data_q, mem_be=1111.
  - sb: mem_be is one-hot at addr_q[1:0].
  - sh: mem_be=0011 if addr_q[1]=0, else 1100.
- Latency, request cycle = cycle 0:
  - sw: WRITE in cycle 1.
  - sb/sh: READ in cycle 1, WAIT in cycles 2..1+RD_LAT, MERGE in cycle 2+RD_LAT, WRITE in cycle 3+RD_LAT.
  - With RD_LAT=1, sb/sh write in cycle 4.
- busy=1 in every non-IDLE state, so a new request is accepted only in IDLE. req_valid asserted while busy is ignored and must be held by the pipeline.
- Back-to-back: a request presented in the first IDLE cycle after WRITE is accepted. There is no dead cycle beyond IDLE.
- Reset mid-operation: the FSM returns to IDLE next cycle and mem_we is never asserted for the aborted request. A write already in progress in the current cycle completes; the write is a single cycle, so it is atomic.
- mem_re and mem_we are never high in the same cycle.

Decomposition:
- Shared package (global defines header): store op codes ST_W=2'b00, ST_B=2'b01, ST_H=2'b10; FSM state encodings IDLE, READ, WAIT, MERGE, WRITE.
- One combinational sub-module, store_merge: inputs op, addr[1:0], old word and new data; outputs the merged word and the 4-bit byte enable. It is reused by the checker model.

Test Plan:
- sw, addr=0x0000_0010, data=0xDEAD_BEEF -> cycle 1: mem_we=1, mem_addr=0x10, mem_wdata=0xDEADBEEF, mem_be=1111, done=1, mem_re never asserted.
- sb, addr=0x0000_0013, data=0x0000_00AB, memory word=0x1122_3344, RD_LAT=1 -> mem_re in cycle 1, mem_we in cycle 4, mem_wdata=0xAB22_3344, mem_be=1000; busy high in cycles 1..4.
- sh, addr=0x0000_0006, data=0x0000_CAFE, memory word=0x1122_3344, RD_LAT=3 -> mem_we in cycle 6, mem_wdata=0xCAFE_3344, mem_be=1100.
- Misaligned sh, addr=0x0000_0005 -> misalign pulse in cycle 1, busy=0, mem_re=mem_we=0. Misaligned sw, addr=0x0000_0002 -> same response.
- sb issued, reset asserted in the WAIT cycle -> no mem_we ever for that request; all outputs 0 next cycle; a following sw is accepted normally.
- Back-to-back sb, addr=0x0 (data 0x11) then sb, addr=0x1 (data 0x22), request held during busy, memory model updates on writes, initial word 0 -> final word 0x0000_2211; second request accepted the cycle after the first done.

Source files
------------

// File: rtl/store_rmw_pkg.sv
// Shared definitions for the store read-modify-write path: op codes,
// FSM state encoding and the alignment rule.
package store_rmw_pkg;

    typedef enum logic [1:0] {
        ST_W   = 2'b00,
        ST_B   = 2'b01,
        ST_H   = 2'b10,
        ST_RSV = 2'b11
    } st_op_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WAIT  = 3'd2,
        MERGE = 3'd3,
        WRITE = 3'd4
    } state_e;

    // Word stores need a word-aligned address, halfword stores an even one.
    function automatic logic is_misaligned(input st_op_e op, input logic [1:0] a);
        return ((op == ST_W) && (a != 2'b00)) || ((op == ST_H) && a[0]);
    endfunction

endpackage

// File: rtl/store_rmw_if.sv
// Pipeline request side and word-memory side of the store unit.
interface store_rmw_if;
    logic        req_valid;
    logic [1:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic        busy;
    logic        done;
    logic        misalign;
    logic [31:0] mem_addr;
    logic        mem_re;
    logic [31:0] mem_rdata;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;

    // master: MEM stage plus data memory; slave: the store unit
    modport master (
        output req_valid, req_op, req_addr, req_data, mem_rdata,
        input  busy, done, misalign, mem_addr, mem_re, mem_we, mem_wdata, mem_be
    );
    modport slave (
        input  req_valid, req_op, req_addr, req_data, mem_rdata,
        output busy, done, misalign, mem_addr, mem_re, mem_we, mem_wdata, mem_be
    );
endinterface

// File: rtl/store_rmw_merge.sv
// Combinational byte-lane merge: drops the new store data into the old
// memory word at the lanes selected by op and the low address bits.
module store_merge
    import store_rmw_pkg::*;
(
    input  st_op_e      op_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] old_i,
    input  logic [31:0] new_i,
    output logic [31:0] merged_o,
    output logic [3:0]  be_o
);
    logic [31:0] src;

    // Replicate the store data across all lanes, then pick per lane by be_o.
    always_comb begin
        be_o = 4'b0000;
        src  = new_i;
        case (op_i)
            ST_W: be_o = 4'b1111;
            ST_B: begin
                be_o = 4'b0001 << addr_i;
                src  = {4{new_i[7:0]}};
            end
            ST_H: begin
                be_o = addr_i[1] ? 4'b1100 : 4'b0011;
                src  = {2{new_i[15:0]}};
            end
            default: be_o = 4'b0000;
        endcase
        for (int b = 0; b < 4; b++) begin
            merged_o[b*8 +: 8] = be_o[b] ? src[b*8 +: 8] : old_i[b*8 +: 8];
        end
    end
endmodule

// File: rtl/store_rmw.sv
// Store unit for a word-only data memory: sw writes directly, sb/sh do a
// read-modify-write while holding busy; misaligned stores are rejected.
module store_rmw
    import store_rmw_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    store_rmw_if.slave st
);
    localparam logic [1:0] CNT_LAST = 2'(RD_LAT - 1);

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    st_op_e      op_q;
    logic [31:0] addr_q, data_q, rdata_q, wdata_q;
    logic [3:0]  be_q;
    logic        misalign_q, misalign_d;
    logic        accept;
    st_op_e      req_op;
    logic [31:0] merged;
    logic [3:0]  merged_be;

    assign req_op = st_op_e'(st.req_op);

    store_merge u_merge (
        .op_i     (op_q),
        .addr_i   (addr_q[1:0]),
        .old_i    (rdata_q),
        .new_i    (data_q),
        .merged_o (merged),
        .be_o     (merged_be)
    );

    // Next-state decode; requests are only looked at in IDLE.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        accept     = 1'b0;
        misalign_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (st.req_valid && (req_op != ST_RSV)) begin
                    if (is_misaligned(req_op, st.req_addr[1:0])) begin
                        misalign_d = 1'b1;
                    end else begin
                        accept  = 1'b1;
                        state_d = (req_op == ST_W) ? WRITE : READ;
                    end
                end
            end
            READ: begin
                state_d = WAIT;
                cnt_d   = 2'd0;
            end
            WAIT: begin
                if (cnt_q == CNT_LAST) state_d = MERGE;
                else                   cnt_d   = cnt_q + 2'd1;
            end
            MERGE:   state_d = WRITE;
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, capture and merge registers; reset aborts any pending RMW.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 2'd0;
            op_q       <= ST_W;
            addr_q     <= '0;
            data_q     <= '0;
            rdata_q    <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            misalign_q <= misalign_d;
            if (accept) begin
                op_q    <= req_op;
                addr_q  <= st.req_addr;
                data_q  <= st.req_data;
                // sw skips MERGE, so its write word is ready at accept
                wdata_q <= st.req_data;
                be_q    <= 4'b1111;
            end
            if ((state_q == WAIT) && (cnt_q == CNT_LAST)) rdata_q <= st.mem_rdata;
            if (state_q == MERGE) begin
                wdata_q <= merged;
                be_q    <= merged_be;
            end
        end
    end

    assign st.busy      = (state_q != IDLE);
    assign st.mem_re    = (state_q == READ);
    assign st.mem_we    = (state_q == WRITE);
    assign st.done      = (state_q == WRITE);
    assign st.misalign  = misalign_q;
    assign st.mem_addr  = {addr_q[31:2], 2'b00};
    assign st.mem_wdata = (state_q == WRITE) ? wdata_q : 32'h0;
    assign st.mem_be    = (state_q == WRITE) ? be_q : 4'h0;
endmodule
